// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared types and constants for the 512x59 SPSRAM access controller.
// Optional zero-fill after reset: CT_SPSRAM_CTRL_ZERO_INIT_EN.
package ct_spsram_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 59;

    localparam logic [DEF_DATA_WIDTH-1:0] WEN_NONE = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/ct_spsram_ctrl_rsp_fifo.sv
// Two-entry response FIFO; rsp data is the registered head entry.
// Part of ct_spsram_512x59_ctrl (see CT_SPSRAM_CTRL_ZERO_INIT_EN there).
module ct_spsram_ctrl_rsp_fifo
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  vld,
    input  logic                  rdy,
    output logic [DATA_WIDTH-1:0] data,
    output logic [1:0]            cnt
);

    logic [DATA_WIDTH-1:0] tail;
    logic                  pop;

    assign vld = (cnt != 2'd0);
    assign pop = vld & rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 2'd0;
            data <= '0;
            tail <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) data <= push_data;
                    else             tail <= push_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    data <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // Full: shift tail forward; single: replace head
                    if (cnt == 2'd2) begin
                        data <= tail;
                        tail <= push_data;
                    end else begin
                        data <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ct_spsram_512x59_ctrl.sv
// Valid/ready front end for the 512x59 single-port SRAM macro.
// Optional post-reset zero sweep: define CT_SPSRAM_CTRL_ZERO_INIT_EN.
module ct_spsram_512x59_ctrl
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q,
    output logic                  idle
);

    if (RSP_DEPTH != 2) begin : g_bad_depth
        $error("RSP_DEPTH must be 2");
    end

    state_t      state;
    logic        run;
    logic        acc;
    logic        wr_acc;
    logic        pop;
    logic        rd_pend;
    logic        rd_ok;
    logic [1:0]  buf_cnt;
    logic [2:0]  credit;

    // Reset gates the handshake so the macro deselects asynchronously
    assign run     = (state == ST_RUN) & ~cpurst;
    assign pop     = rsp_vld & rsp_rdy;
    assign credit  = {1'b0, buf_cnt} + {2'b0, rd_pend} - {2'b0, pop};
    assign rd_ok   = (credit < 3'd2);
    assign req_rdy = run & rd_ok;
    assign acc     = req_vld & req_rdy;
    assign wr_acc  = acc & req_wr;
    assign idle    = run & ~rd_pend & (buf_cnt == 2'd0);

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) rd_pend <= 1'b0;
        else        rd_pend <= acc & ~req_wr;
    end

`ifdef CT_SPSRAM_CTRL_ZERO_INIT_EN
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  init_act;

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state     <= ST_INIT;
            init_addr <= '0;
        end else if (state == ST_INIT) begin
            init_addr <= init_addr + ADDR_ONE;
            if (&init_addr) state <= ST_RUN;
        end
    end

    assign init_act  = (state == ST_INIT) & ~cpurst;
    assign sram_cen  = ~(acc | init_act);
    assign sram_gwen = ~(wr_acc | init_act);
    assign sram_wen  = init_act ? '0
                     : wr_acc   ? ~req_wmask
                     :            WEN_NONE[DATA_WIDTH-1:0];
    assign sram_a    = init_act ? init_addr : req_addr;
    assign sram_d    = init_act ? '0 : req_wdata;
`else
    assign state     = ST_RUN;
    assign sram_cen  = ~acc;
    assign sram_gwen = ~wr_acc;
    assign sram_wen  = wr_acc ? ~req_wmask : WEN_NONE[DATA_WIDTH-1:0];
    assign sram_a    = req_addr;
    assign sram_d    = req_wdata;
`endif

    ct_spsram_ctrl_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (forever_cpuclk),
        .rst       (cpurst),
        .push      (rd_pend),
        .push_data (sram_q),
        .vld       (rsp_vld),
        .rdy       (rsp_rdy),
        .data      (rsp_rdata),
        .cnt       (buf_cnt)
    );

endmodule

// File: tb/tb_ct_spsram_512x59_ctrl.sv
// Directed bench for ct_spsram_512x59_ctrl with a behavioural SRAM.
// Zero-sweep scenario runs when CT_SPSRAM_CTRL_ZERO_INIT_EN is defined.
module tb_ct_spsram_512x59_ctrl;
    import ct_spsram_ctrl_pkg::*;

    localparam int AW = 9;
    localparam int DW = 59;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_vld = 1'b0;
    logic          req_rdy;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [DW-1:0] req_wmask = '0;
    logic          rsp_vld;
    logic          rsp_rdy = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q = '0;
    logic          idle;

    int n_cmp = 0;
    int n_fail = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= mem[sram_a];
        end
    end

    ct_spsram_512x59_ctrl dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .rsp_vld        (rsp_vld),
        .rsp_rdy        (rsp_rdy),
        .rsp_rdata      (rsp_rdata),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_a         (sram_a),
        .sram_d         (sram_d),
        .sram_q         (sram_q),
        .idle           (idle)
    );

    task automatic drive_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] m);
        req_vld = 1'b1; req_wr = 1'b1;
        req_addr = a; req_wdata = d; req_wmask = m;
    endtask

    task automatic drive_rd(input logic [AW-1:0] a);
        req_vld = 1'b1; req_wr = 1'b0;
        req_addr = a; req_wdata = '0; req_wmask = '0;
    endtask

    task automatic drive_none();
        req_vld = 1'b0; req_wr = 1'b0;
    endtask

    task automatic wait_ready();
`ifdef CT_SPSRAM_CTRL_ZERO_INIT_EN
        int k;
        k = 0;
        while (req_rdy !== 1'b1 && k < 600) begin
            @(negedge clk); #1;
            k++;
        end
        n_cmp++;
        if (req_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL init_timeout: req_rdy=%b want 1", req_rdy);
        end
`endif
    endtask

    task automatic test_reset();
        drive_rd(9'h010);
        @(negedge clk); #1;
        n_cmp++; if (rsp_vld !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_vld: got %b want 0", rsp_vld); end
        n_cmp++; if (rsp_rdata !== '0) begin n_fail++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
        n_cmp++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_req_rdy: got %b want 0", req_rdy); end
        n_cmp++; if (sram_cen !== 1'b1) begin n_fail++; $display("FAIL rst_cen: got %b want 1", sram_cen); end
        n_cmp++; if (sram_gwen !== 1'b1) begin n_fail++; $display("FAIL rst_gwen: got %b want 1", sram_gwen); end
        n_cmp++; if (sram_wen !== {DW{1'b1}}) begin n_fail++; $display("FAIL rst_wen: got %h want all-1", sram_wen); end
        n_cmp++; if (idle !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got %b want 0", idle); end
        drive_none();
        rst = 1'b0;
        #1;
`ifdef CT_SPSRAM_CTRL_ZERO_INIT_EN
        n_cmp++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL init_rdy: got %b want 0", req_rdy); end
        wait_ready();
`else
        n_cmp++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL rel_req_rdy: got %b want 1", req_rdy); end
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rel_idle: got %b want 1", idle); end
        n_cmp++; if (sram_cen !== 1'b1) begin n_fail++; $display("FAIL rel_cen: got %b want 1", sram_cen); end
`endif
    endtask

    task automatic test_write_read();
        rsp_rdy = 1'b1;
        @(negedge clk);
        drive_wr(9'h1A5, 59'h5A5A5A5A5A5A5A5, '1);
        #1;
        n_cmp++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL wr_rdy: got %b want 1", req_rdy); end
        n_cmp++; if (sram_cen !== 1'b0) begin n_fail++; $display("FAIL wr_cen: got %b want 0", sram_cen); end
        n_cmp++; if (sram_gwen !== 1'b0) begin n_fail++; $display("FAIL wr_gwen: got %b want 0", sram_gwen); end
        n_cmp++; if (sram_wen !== '0) begin n_fail++; $display("FAIL wr_wen: got %h want 0", sram_wen); end
        @(negedge clk);
        drive_rd(9'h1A5);
        #1;
        n_cmp++; if (sram_cen !== 1'b0) begin n_fail++; $display("FAIL rd_cen: got %b want 0", sram_cen); end
        n_cmp++; if (sram_gwen !== 1'b1) begin n_fail++; $display("FAIL rd_gwen: got %b want 1", sram_gwen); end
        n_cmp++; if (sram_a !== 9'h1A5) begin n_fail++; $display("FAIL rd_a: got %h want 1a5", sram_a); end
        @(negedge clk);
        drive_none();
        #1;
        n_cmp++; if (rsp_vld !== 1'b0) begin n_fail++; $display("FAIL rd_lat1: rsp_vld=%b want 0", rsp_vld); end
        n_cmp++; if (idle !== 1'b0) begin n_fail++; $display("FAIL rd_pend_idle: got %b want 0", idle); end
        @(negedge clk); #1;
        n_cmp++; if (rsp_vld !== 1'b1) begin n_fail++; $display("FAIL rd_lat2: rsp_vld=%b want 1", rsp_vld); end
        n_cmp++; if (rsp_rdata !== 59'h5A5A5A5A5A5A5A5) begin n_fail++; $display("FAIL rd_data: got %h want 5a5a5a5a5a5a5a5", rsp_rdata); end
        @(negedge clk); #1;
        n_cmp++; if (rsp_vld !== 1'b0) begin n_fail++; $display("FAIL rd_pop: rsp_vld=%b want 0", rsp_vld); end
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rd_idle: got %b want 1", idle); end
    endtask

    task automatic test_masked_write();
        rsp_rdy = 1'b1;
        @(negedge clk);
        drive_wr(9'h003, '0, '1);
        #1;
        n_cmp++; if (sram_gwen !== 1'b0) begin n_fail++; $display("FAIL mw1_gwen: got %b want 0", sram_gwen); end
        n_cmp++; if (sram_wen !== '0) begin n_fail++; $display("FAIL mw1_wen: got %h want 0", sram_wen); end
        @(negedge clk);
        drive_wr(9'h003, '1, 59'h00000000FFFFFFF);
        #1;
        n_cmp++; if (sram_gwen !== 1'b0) begin n_fail++; $display("FAIL mw2_gwen: got %b want 0", sram_gwen); end
        n_cmp++; if (sram_wen !== 59'h7FFFFFFF0000000) begin n_fail++; $display("FAIL mw2_wen: got %h want 7ffffff f0000000", sram_wen); end
        @(negedge clk);
        drive_rd(9'h003);
        @(negedge clk);
        drive_none();
        @(negedge clk); #1;
        n_cmp++; if (rsp_vld !== 1'b1) begin n_fail++; $display("FAIL mw_vld: got %b want 1", rsp_vld); end
        n_cmp++; if (rsp_rdata !== 59'h00000000FFFFFFF) begin n_fail++; $display("FAIL mw_data: got %h want 00000000fffffff", rsp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp;
        rsp_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_wr(AW'(i), DW'(10 + i), '1);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i < 4) drive_rd(AW'(i));
            else       drive_none();
            #1;
            if (i < 4) begin
                n_cmp++;
                if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy%0d: got %b want 1", i, req_rdy); end
            end
            if (i >= 2) begin
                exp = DW'(8 + i);
                n_cmp++;
                if (rsp_vld !== 1'b1 || rsp_rdata !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_rsp%0d: vld=%b data=%0d want vld=1 data=%0d", i - 2, rsp_vld, rsp_rdata, exp);
                end
            end
        end
        @(negedge clk); #1;
        n_cmp++; if (rsp_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_end_vld: got %b want 0", rsp_vld); end
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: got %b want 1", idle); end
    endtask

    task automatic test_backpressure();
        rsp_rdy = 1'b0;
        @(negedge clk); drive_rd(9'h000); #1;
        n_cmp++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy0: got %b want 1", req_rdy); end
        @(negedge clk); drive_rd(9'h001); #1;
        n_cmp++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy1: got %b want 1", req_rdy); end
        @(negedge clk); drive_rd(9'h002); #1;
        n_cmp++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy2: got %b want 0", req_rdy); end
        @(negedge clk); #1;
        n_cmp++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy3: got %b want 0", req_rdy); end
        n_cmp++; if (rsp_vld !== 1'b1 || rsp_rdata !== 59'd10) begin n_fail++; $display("FAIL bp_head: vld=%b data=%0d want 1/10", rsp_vld, rsp_rdata); end
        @(negedge clk); rsp_rdy = 1'b1; #1;
        n_cmp++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_pop_rdy: got %b want 1", req_rdy); end
        @(negedge clk); drive_none(); #1;
        n_cmp++; if (rsp_vld !== 1'b1 || rsp_rdata !== 59'd11) begin n_fail++; $display("FAIL bp_rsp1: vld=%b data=%0d want 1/11", rsp_vld, rsp_rdata); end
        @(negedge clk); #1;
        n_cmp++; if (rsp_vld !== 1'b1 || rsp_rdata !== 59'd12) begin n_fail++; $display("FAIL bp_rsp2: vld=%b data=%0d want 1/12", rsp_vld, rsp_rdata); end
        @(negedge clk); #1;
        n_cmp++; if (rsp_vld !== 1'b0) begin n_fail++; $display("FAIL bp_dup: rsp_vld=%b want 0", rsp_vld); end
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got %b want 1", idle); end
    endtask

    task automatic test_reset_inflight();
        rsp_rdy = 1'b0;
        @(negedge clk); drive_rd(9'h001);
        @(negedge clk); drive_rd(9'h002);
        @(negedge clk); drive_rd(9'h000); #1;
        n_cmp++; if (rsp_vld !== 1'b1 || idle !== 1'b0) begin n_fail++; $display("FAIL ri_pre: vld=%b idle=%b want 1/0", rsp_vld, idle); end
        rst = 1'b1;
        #1;
        n_cmp++; if (rsp_vld !== 1'b0) begin n_fail++; $display("FAIL ri_vld: got %b want 0", rsp_vld); end
        n_cmp++; if (sram_cen !== 1'b1) begin n_fail++; $display("FAIL ri_cen: got %b want 1", sram_cen); end
        n_cmp++; if (req_rdy !== 1'b0) begin n_fail++; $display("FAIL ri_rdy: got %b want 0", req_rdy); end
        @(negedge clk);
        drive_none();
        rsp_rdy = 1'b1;
        rst = 1'b0;
        #1;
        wait_ready();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (rsp_vld !== 1'b0) begin n_fail++; $display("FAIL ri_stale%0d: rsp_vld=%b want 0", i, rsp_vld); end
        end
        n_cmp++; if (idle !== 1'b1) begin n_fail++; $display("FAIL ri_idle: got %b want 1", idle); end
    endtask

`ifdef CT_SPSRAM_CTRL_ZERO_INIT_EN
    task automatic test_zero_init();
        @(negedge clk);
        drive_none();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 512; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            n_cmp++;
            if (req_rdy !== 1'b0 || sram_a !== AW'(i) || sram_cen !== 1'b0) begin
                n_fail++;
                $display("FAIL zi_sweep%0d: rdy=%b a=%0d cen=%b want 0/%0d/0", i, req_rdy, sram_a, sram_cen, i);
            end
        end
        @(negedge clk); #1;
        n_cmp++; if (req_rdy !== 1'b1) begin n_fail++; $display("FAIL zi_rdy: got %b want 1", req_rdy); end
        rsp_rdy = 1'b1;
        drive_rd(9'h1FF);
        @(negedge clk); drive_none();
        @(negedge clk); #1;
        n_cmp++; if (rsp_vld !== 1'b1 || rsp_rdata !== '0) begin n_fail++; $display("FAIL zi_data: vld=%b data=%h want 1/0", rsp_vld, rsp_rdata); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_masked_write();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
`ifdef CT_SPSRAM_CTRL_ZERO_INIT_EN
        test_zero_init();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
